i2s_rx: RTL and testbench

Slave I2S receiver that deserializes the ADC/codec serial stream into parallel signed left/right samples for `effect_controler`. It samples the externally generated bit and word clocks in the system clock domain and presents each completed stereo pair on `o_l_data`/`o_r_data` with a one-cycle `o_valid` strobe. Outputs connect directly to `i_l_data`/`i_r_data`.

---
 rtl/i2s_rx.sv | 174 +++++++++++++++++
 tb/tb_i2s_rx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: slave I2S receiver; oversamples bclk/lrclk/sdata in the clk domain
// and emits each stereo pair as signed parallel words with a one-cycle strobe.
// Ports: clk, rst_n (async, active-low), i_bclk, i_lrclk (0=left), i_sdata
//   -> o_l_data, o_r_data (held between strobes), o_valid, o_frame_err.
// Option: define I2S_RX_ERR_DET_EN to flag and suppress pairs with short words;
//   otherwise o_frame_err is tied low and short words are emitted zero-padded.
module i2s_rx #(
    parameter int d_width = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_bclk,
    input  logic                      i_lrclk,
    input  logic                      i_sdata,
    output logic signed [d_width-1:0] o_l_data,
    output logic signed [d_width-1:0] o_r_data,
    output logic                      o_valid,
    output logic                      o_frame_err
);

    localparam int CW = $clog2(d_width + 2);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t state, state_n;

    logic [1:0] bclk_sy, lrclk_sy, sdata_sy;
    logic       bclk_d;
    logic       rise_p, lr_p, sd_p;
    logic       lr_prev;

    logic [d_width-1:0] sreg, word, l_hold;
    logic [CW-1:0]      cnt;

    logic boundary;
    logic latch_l, load, pair_ok;

    // Identical two-flop chains keep pin-to-pin skew bounded to one clk.
    // The rise strobe and the sampled ws/data are registered together so all
    // word decisions happen one edge later, on a single consistent snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sy  <= '0;
            lrclk_sy <= '0;
            sdata_sy <= '0;
            bclk_d   <= 1'b0;
            rise_p   <= 1'b0;
            lr_p     <= 1'b0;
            sd_p     <= 1'b0;
        end else begin
            bclk_sy  <= {bclk_sy[0], i_bclk};
            lrclk_sy <= {lrclk_sy[0], i_lrclk};
            sdata_sy <= {sdata_sy[0], i_sdata};
            bclk_d   <= bclk_sy[1];
            rise_p   <= bclk_sy[1] & ~bclk_d;
            lr_p     <= lrclk_sy[1];
            sd_p     <= sdata_sy[1];
        end
    end

    assign boundary = rise_p && (lr_p != lr_prev);

    // Current word with this rise's bit placed MSB-first; slots longer than
    // d_width leave cnt past the last index, so the extra bits drop out.
    always_comb begin
        word = sreg;
        for (int i = 0; i < d_width; i++) begin
            if (cnt == CW'(i)) word[d_width-1-i] = sd_p;
        end
    end

`ifdef I2S_RX_ERR_DET_EN
    logic [CW:0] bits;
    logic        short_w, l_short, err;

    assign bits    = {1'b0, cnt} + (CW + 1)'(1);
    assign short_w = bits < (CW + 1)'(d_width);
    assign pair_ok = ~(short_w | l_short);
`else
    assign pair_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch_l = 1'b0;
        load    = 1'b0;
`ifdef I2S_RX_ERR_DET_EN
        err     = 1'b0;
`endif
        if (boundary) begin
            unique case (state)
                SYNC: begin
                    if (!lr_p) state_n = LEFT;
                end
                LEFT: begin
                    if (lr_p) begin
                        state_n = RIGHT;
                        latch_l = 1'b1;
`ifdef I2S_RX_ERR_DET_EN
                        err     = short_w;
`endif
                    end
                end
                RIGHT: begin
                    if (!lr_p) begin
                        state_n = LEFT;
                        load    = pair_ok;
`ifdef I2S_RX_ERR_DET_EN
                        err     = short_w;
`endif
                    end
                end
                default: state_n = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            lr_prev <= 1'b1;
        end else if (rise_p) begin
            if (boundary) begin
                sreg    <= '0;
                cnt     <= '0;
                lr_prev <= lr_p;
            end else begin
                sreg <= word;
                if (cnt < CW'(d_width + 1)) cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_hold   <= '0;
            o_l_data <= '0;
            o_r_data <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= load;
            if (latch_l) l_hold <= word;
            if (load) begin
                o_l_data <= l_hold;
                o_r_data <= word;
            end
        end
    end

`ifdef I2S_RX_ERR_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_short     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= err;
            if (latch_l) l_short <= short_w;
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stream driver with a word-level reference model
// and an on-the-fly scoreboard for the i2s_rx pair outputs.
module tb_i2s_rx;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_bclk = 1'b0;
    logic          i_lrclk = 1'b1;
    logic          i_sdata = 1'b0;
    logic [DW-1:0] o_l_data, o_r_data;
    logic          o_valid, o_frame_err;

    i2s_rx #(.d_width(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bclk     (i_bclk),
        .i_lrclk    (i_lrclk),
        .i_sdata    (i_sdata),
        .o_l_data   (o_l_data),
        .o_r_data   (o_r_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Stream and model state.
    logic          ws_prev = 1'b1;
    logic          pend = 1'b0;
    bit            pw_valid = 0;
    logic          pw_lr;
    logic [31:0]   pw_slot;
    int            pw_n;
    bit            pw_bs;
    bit            lp_ok = 0;
    bit            lp_sh = 0;
    logic [DW-1:0] lp;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];
    int            exp_err = 0;
    int            obs_err = 0;

    // Word-level model: a stereo pair is a left word that began on a 1->0
    // boundary followed by a right word; samples are the top DW slot bits.
    task automatic model_word(input logic lr, input logic [31:0] slot,
                              input int n, input bit bs);
        logic [DW-1:0] s;
        bit sh;
        if (n >= DW) s = DW'(slot >> (n - DW));
        else         s = DW'(slot << (DW - n));
        sh = (n < DW);
        if (!lr) begin
            lp_ok = bs;
            lp    = s;
            lp_sh = sh;
`ifdef I2S_RX_ERR_DET_EN
            if (bs && sh) exp_err++;
`endif
        end else if (lp_ok) begin
            lp_ok = 0;
`ifdef I2S_RX_ERR_DET_EN
            if (sh) exp_err++;
            if (!(sh || lp_sh)) begin
                exp_l.push_back(lp);
                exp_r.push_back(s);
                last_l = lp;
                last_r = s;
            end
`else
            exp_l.push_back(lp);
            exp_r.push_back(s);
            last_l = lp;
            last_r = s;
`endif
        end
    endtask

    // One bclk period (8 clk): ws/data change on the fall, sampled on the rise.
    task automatic bit_cycle(input logic lr, input logic b, input bit chk);
        i_bclk  = 1'b0;
        i_lrclk = lr;
        i_sdata = b;
        repeat (4) @(negedge clk);
        i_bclk = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (chk) begin
                n_run++;
                if (o_valid !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL latency clk%0d: o_valid=%b want %b",
                             i, o_valid, (i == 4));
                end
            end
        end
    endtask

    // Cycle 0 of a word carries the previous word's last bit (I2S delay).
    task automatic send_word(input logic lr, input logic [31:0] slot,
                             input int n, input bit chk);
        if (pw_valid && lr != ws_prev)
            model_word(pw_lr, pw_slot, pw_n, pw_bs);
        pw_bs    = (lr != ws_prev);
        pw_lr    = lr;
        pw_slot  = slot;
        pw_n     = n;
        pw_valid = 1;
        ws_prev  = lr;
        for (int k = 0; k < n; k++)
            bit_cycle(lr, (k == 0) ? pend : slot[n-k], chk && k == 0);
        pend = slot[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_bclk  = 1'b0;
        i_lrclk = 1'b1;
        i_sdata = 1'b0;
        ws_prev = 1'b1;
        pend    = 1'b0;
        pw_valid = 0;
        lp_ok   = 0;
        last_l  = '0;
        last_r  = '0;
        exp_l.delete();
        exp_r.delete();
        exp_err = 0;
        obs_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every strobe must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_frame_err) obs_err++;
            if (o_valid) begin
                n_run++;
                if (exp_l.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: l=%h r=%h",
                             o_l_data, o_r_data);
                end else begin
                    logic [DW-1:0] el, er;
                    el = exp_l.pop_front();
                    er = exp_r.pop_front();
                    if (o_l_data !== el || o_r_data !== er) begin
                        n_fail++;
                        $display("FAIL pair: got %h/%h want %h/%h",
                                 o_l_data, o_r_data, el, er);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_run++;
        if (o_l_data !== '0) begin
            n_fail++;
            $display("FAIL reset_l: got %h want 0", o_l_data);
        end
        n_run++;
        if (o_r_data !== '0) begin
            n_fail++;
            $display("FAIL reset_r: got %h want 0", o_r_data);
        end
        n_run++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        n_run++;
        if (o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", o_frame_err);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        send_word(1'b0, 32'h123456, 24, 0);
        send_word(1'b1, 32'hABCDEF, 24, 0);
        send_word(1'b0, $urandom, 2, 1);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_missing: %0d pending want 0", exp_l.size());
        end
        n_run++;
        if (o_l_data !== 24'h123456 || o_r_data !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL nominal_out: got %h/%h want 123456/abcdef",
                     o_l_data, o_r_data);
        end
    endtask

    task automatic test_slot32();
        do_reset();
        send_word(1'b0, {8'h80, 16'h0001, 8'hFF}, 32, 0);
        send_word(1'b1, {8'h7F, 16'hFFFF, 8'h00}, 32, 0);
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL slot32_missing: %0d pending want 0", exp_l.size());
        end
        n_run++;
        if (o_l_data !== last_l || o_r_data !== last_r) begin
            n_fail++;
            $display("FAIL slot32_out: got %h/%h want %h/%h",
                     o_l_data, o_r_data, last_l, last_r);
        end
    endtask

    task automatic test_mid_right_start();
        do_reset();
        send_word(1'b1, $urandom, 11, 0);
        send_word(1'b0, $urandom, 24, 0);
        send_word(1'b1, $urandom, 24, 0);
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL midright_missing: %0d pending want 0", exp_l.size());
        end
        n_run++;
        if (o_l_data !== last_l || o_r_data !== last_r) begin
            n_fail++;
            $display("FAIL midright_out: got %h/%h want %h/%h",
                     o_l_data, o_r_data, last_l, last_r);
        end
    endtask

    task automatic test_short();
        do_reset();
        send_word(1'b0, $urandom, 24, 0);
        send_word(1'b1, $urandom, 24, 0);
        send_word(1'b0, 32'h1234, 16, 0);
        send_word(1'b1, 32'hBEEF, 16, 0);
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL short_missing: %0d pending want 0", exp_l.size());
        end
        n_run++;
        if (obs_err != exp_err) begin
            n_fail++;
            $display("FAIL short_err: got %0d pulses want %0d",
                     obs_err, exp_err);
        end
        n_run++;
        if (o_l_data !== last_l || o_r_data !== last_r) begin
            n_fail++;
            $display("FAIL short_out: got %h/%h want %h/%h",
                     o_l_data, o_r_data, last_l, last_r);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        send_word(1'b0, $urandom, 24, 0);
        send_word(1'b1, $urandom, 24, 0);
        send_word(1'b0, $urandom, 10, 0);
        n_run++;
        if (exp_l.size() != 0 || o_l_data !== last_l) begin
            n_fail++;
            $display("FAIL pre_reset: l=%h want %h pending=%0d",
                     o_l_data, last_l, exp_l.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if (o_l_data !== '0 || o_r_data !== '0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h v=%b want 0/0 v=0",
                     o_l_data, o_r_data, o_valid);
        end
        do_reset();
        send_word(1'b1, $urandom, 9, 0);
        send_word(1'b0, $urandom, 24, 0);
        send_word(1'b1, $urandom, 24, 0);
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_missing: %0d pending", exp_l.size());
        end
        n_run++;
        if (o_l_data !== last_l || o_r_data !== last_r) begin
            n_fail++;
            $display("FAIL post_reset_out: got %h/%h want %h/%h",
                     o_l_data, o_r_data, last_l, last_r);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] base;
        int npairs;
        base = DW'($urandom);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_word(1'b0, 32'(DW'(base + DW'(2 * i))), 24, 0);
            send_word(1'b1, 32'(DW'(base + DW'(2 * i + 1))), 24, 0);
        end
        npairs = 10;
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing: %0d of %0d pending",
                     exp_l.size(), npairs);
        end
        n_run++;
        if (o_l_data !== DW'(base + 18) || o_r_data !== DW'(base + 19)) begin
            n_fail++;
            $display("FAIL b2b_last: got %h/%h want %h/%h", o_l_data,
                     o_r_data, DW'(base + 18), DW'(base + 19));
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) n = $urandom_range(16, 23);
            else                           n = $urandom_range(24, 32);
            send_word(i[0], $urandom, n, 0);
        end
        send_word(1'b0, $urandom, 2, 0);
        n_run++;
        if (exp_l.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing: %0d pending want 0", exp_l.size());
        end
        n_run++;
        if (obs_err != exp_err) begin
            n_fail++;
            $display("FAIL rand_err: got %0d pulses want %0d",
                     obs_err, exp_err);
        end
        n_run++;
        if (o_l_data !== last_l || o_r_data !== last_r) begin
            n_fail++;
            $display("FAIL rand_out: got %h/%h want %h/%h",
                     o_l_data, o_r_data, last_l, last_r);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slot32();
        test_mid_right_start();
        test_short();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
